// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the scoreboarded register file: FSM state encoding
// and the default geometry used by the interface and the modules.
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRP_DEF   = 2;

  typedef enum logic {
    SCRUB = 1'b0,
    READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_sb_if.sv
// Bundle of write, issue and read signals between a pipeline front end and
// the scoreboarded register file.
interface regfile_sb_if
  import rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRP   = NRP_DEF
);
  localparam int AW = $clog2(NREGS);

  logic                wr0_en;
  logic [AW-1:0]       wr0_addr;
  logic [XLEN-1:0]     wr0_data;
  logic                wr1_en;
  logic [AW-1:0]       wr1_addr;
  logic [XLEN-1:0]     wr1_data;
  logic [NRP*AW-1:0]   rd_addr;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NRP-1:0]      rd_pend;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                init_done;

  modport master (
    output wr0_en, wr0_addr, wr0_data,
    output wr1_en, wr1_addr, wr1_data,
    output rd_addr, iss_en, iss_addr,
    input  rd_data, rd_pend, init_done
  );

  modport slave (
    input  wr0_en, wr0_addr, wr0_data,
    input  wr1_en, wr1_addr, wr1_data,
    input  rd_addr, iss_en, iss_addr,
    output rd_data, rd_pend, init_done
  );

endinterface

// File: rtl/regfile_sb_read_port.sv
// One read port: write-through bypass from both write ports and the pending
// flag masked by any same-cycle write-back to the addressed register.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = 5
) (
  input  logic            ready,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] stored,
  input  logic            pend_bit,
  input  logic            wr0_en,
  input  logic [AW-1:0]   wr0_addr,
  input  logic [XLEN-1:0] wr0_data,
  input  logic            wr1_en,
  input  logic [AW-1:0]   wr1_addr,
  input  logic [XLEN-1:0] wr1_data,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_pend
);

  logic live;
  logic hit0;
  logic hit1;

  assign live = ready && (rd_addr != '0);
  assign hit0 = wr0_en && (wr0_addr == rd_addr);
  assign hit1 = wr1_en && (wr1_addr == rd_addr);

  // x0 and the whole scrub window read as zero and never pending
  always_comb begin
    rd_data = '0;
    rd_pend = 1'b0;
    if (live) begin
      if (hit1) begin
        rd_data = wr1_data;
      end else if (hit0) begin
        rd_data = wr0_data;
      end else begin
        rd_data = stored;
      end
      rd_pend = pend_bit && !(hit0 || hit1);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with two write ports, NRP bypassed read ports and a pending
// scoreboard; contents are zeroed by a one-register-per-cycle scrub after reset.
module regfile_sb
  import rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRP   = NRP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  regfile_sb_if.slave bus
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] CNT_LAST = AW'(NREGS - 1);

  rf_state_e       state;
  rf_state_e       state_nxt;
  logic [AW-1:0]   cnt;
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] pend;

  logic ready;
  logic wr0_ok;
  logic wr1_ok;
  logic iss_ok;

  assign ready  = (state == READY);
  assign wr0_ok = ready && bus.wr0_en && (bus.wr0_addr != '0);
  assign wr1_ok = ready && bus.wr1_en && (bus.wr1_addr != '0);
  assign iss_ok = ready && bus.iss_en && (bus.iss_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SCRUB;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == SCRUB) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if ((state == SCRUB) && (cnt == CNT_LAST)) begin
      state_nxt = READY;
    end
  end

  // wr1 is written last so it wins a same-address collision with wr0
  always_ff @(posedge clk) begin
    if (!ready) begin
      regs[cnt] <= '0;
    end else if (!rst) begin
      if (wr0_ok) begin
        regs[bus.wr0_addr] <= bus.wr0_data;
      end
      if (wr1_ok) begin
        regs[bus.wr1_addr] <= bus.wr1_data;
      end
    end
  end

  // An issue to the register being written back this cycle keeps it pending
  always_ff @(posedge clk) begin
    if (!ready) begin
      pend[cnt] <= 1'b0;
    end else if (!rst) begin
      if (wr0_ok) begin
        pend[bus.wr0_addr] <= 1'b0;
      end
      if (wr1_ok) begin
        pend[bus.wr1_addr] <= 1'b0;
      end
      if (iss_ok) begin
        pend[bus.iss_addr] <= 1'b1;
      end
    end
  end

  logic [XLEN-1:0] rd_data_a [NRP];
  logic [NRP-1:0]  rd_pend_v;

  for (genvar k = 0; k < NRP; k++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = bus.rd_addr[k*AW +: AW];

    rf_read_port #(
      .XLEN (XLEN),
      .AW   (AW)
    ) u_port (
      .ready    (ready),
      .rd_addr  (addr),
      .stored   (regs[addr]),
      .pend_bit (pend[addr]),
      .wr0_en   (wr0_ok),
      .wr0_addr (bus.wr0_addr),
      .wr0_data (bus.wr0_data),
      .wr1_en   (wr1_ok),
      .wr1_addr (bus.wr1_addr),
      .wr1_data (bus.wr1_data),
      .rd_data  (rd_data_a[k]),
      .rd_pend  (rd_pend_v[k])
    );
  end

  always_comb begin
    bus.rd_data = '0;
    for (int k = 0; k < NRP; k++) begin
      bus.rd_data[k*XLEN +: XLEN] = rd_data_a[k];
    end
  end

  assign bus.rd_pend   = rd_pend_v;
  assign bus.init_done = ready;

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count; power of two, at least 4.
REQ-003 SHALL have parameter NRP, default 2, number of read ports; range 1..4.
REQ-004 SHALL have localparam AW = clog2(NREGS).
REQ-005 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port wr0_en / wr0_addr / wr0_data  in  1 / AW / XLEN  write port 0.
REQ-008 SHALL have port wr1_en / wr1_addr / wr1_data  in  1 / AW / XLEN  write port 1, higher priority.
REQ-009 SHALL have port rd_addr  in  NRP*AW  packed read addresses, port k at bits [k*AW +: AW].
REQ-010 SHALL have port rd_data  out  NRP*XLEN  packed read data, combinational.
REQ-011 SHALL have port rd_pend  out  NRP  per-port "operand not yet written back" flag, combinational.
REQ-012 SHALL have port iss_en / iss_addr  in  1 / AW  marks destination register pending.
REQ-013 SHALL have port init_done  out  1  high once the scrub sequence completes.

Function
REQ-014 SHALL implement a two-state FSM, SCRUB and READY, with a scrub counter of width AW.
REQ-015 In SCRUB, each cycle SHALL write 0 to reg[cnt] and clear pend[cnt], then increment cnt; cnt = NREGS-1 SHALL cause the transition to READY on the next edge.
REQ-016 Scrub latency SHALL be exactly NREGS cycles: init_done rises on the NREGS-th rising edge after the cycle in which rst is high.
REQ-017 In SCRUB, wr0/wr1/iss SHALL be ignored, rd_data SHALL read 0 and rd_pend SHALL read 0.
REQ-018 In READY, enabled writes to a nonzero address SHALL update the register at the rising edge.
REQ-019 When wr0 and wr1 target the same address, wr1_data SHALL be stored.
REQ-020 A read of address 0 SHALL return 0 with rd_pend 0, regardless of any writes or issues.
REQ-021 Read bypass: if wr1 is enabled to rd_addr[k] (nonzero), rd_data[k] SHALL be wr1_data; else if wr0 matches, wr0_data; else the stored value.
REQ-022 iss_en with nonzero iss_addr SHALL set pend[iss_addr]; an issue to an already pending register leaves it pending (no count).
REQ-023 A write (either port) SHALL clear pend[wr_addr]; if iss_addr equals a write address in the same cycle, set SHALL win.
REQ-024 rd_pend[k] SHALL be pend[rd_addr[k]] AND NOT (a same-cycle write to rd_addr[k]).
REQ-025 All read ports SHALL be independent; any number may read the same address.

Reset
REQ-026 rst high SHALL force the FSM to SCRUB, cnt to 0 and init_done to 0 at the next edge; this applies mid-scrub and in READY.
REQ-027 Register and pend contents SHALL be defined only through the scrub; there is no parallel clear.
REQ-028 rst held high for multiple cycles SHALL keep cnt at 0; scrub starts on the first edge with rst low.

Structure
REQ-029 FSM state enum and the XLEN/NREGS defaults SHALL live in shared package rf_pkg.
REQ-030 Bypass and pending-mask logic for one read port SHALL be sub-module rf_read_port, instantiated NRP times through a generate loop.
REQ-031 Register storage SHALL be a single array with one write per cycle per port, with no reads of the array's reset value.

Verification
REQ-032 rst 1 cycle, NREGS=32 -> init_done low for 32 edges, high on the 32nd; all reads 0 during scrub.
REQ-033 wr0 x5=0xAAAA_0001 and wr1 x5=0x5555_0002 in the same cycle, rd_addr0=5 -> rd_data0=0x5555_0002 that cycle and thereafter.
REQ-034 iss x7; next cycle rd_addr1=7 -> rd_pend1=1; wr0 x7=0x1234 -> same cycle rd_pend1=0, rd_data1=0x1234.
REQ-035 iss x9 and wr1 x9=0xFF in the same cycle -> x9 stores 0xFF, pend[9] remains 1.
REQ-036 wr0 x0=0xDEAD and iss x0 -> rd x0 returns 0 with rd_pend 0.
REQ-037 rst asserted at scrub cnt=10 -> scrub restarts at 0, init_done after a full 32 further edges.
